corelet_ctrl: RTL and testbench
===============================

# corelet_ctrl

Instruction sequencer that drives the corelet's 34-bit `inst` bus and the surrounding activation/weight SRAM (xmem) and partial-sum SRAM (pmem) for one full convolution layer. It is the initiator side of the corelet instruction interface: for every kernel position it fills L0 with weights, loads them into the MAC array, streams activations through L0 to execute, and drains the output FIFO into pmem. It then runs the SFP accumulation pass over pmem. It sits at the top level beside the corelet, replacing testbench-driven `inst` sequences.

## Interface
- `row`, 8: MAC array rows; L0 width in words.
- `col`, 8: MAC array columns; weight words per kernel position.
- `cnt_bw`, 11: width of all address outputs and counters.
- `pipe_lat`, 16: cycles waited after the last execute before the first `ofifo_rd`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; accepted only in IDLE.
- `len_kij` in 4: kernel positions, ≥1.
- `len_nij` in cnt_bw: activation words per kernel position, ≥1.
- `len_onij` in cnt_bw: output pixels, ≥1.
- `w_base` in cnt_bw: xmem address of the first weight word.
- `inst` out 34: corelet instruction. Bit 0 load, 1 execute, 2 l0_wr, 3 l0_rd, 4 ififo_rd, 5 ififo_wr, 6 ofifo_rd, 32 sfp_clr, 33 acc. All other bits are 0.
- `xmem_ren`, `xmem_addr` out 1 / cnt_bw: xmem read.
- `pmem_wen`, `pmem_waddr` out 1 / cnt_bw: pmem write of corelet `data_out`.
- `pmem_ren`, `pmem_raddr` out 1 / cnt_bw: pmem read feeding `data_in_acc`.
- `res_valid`, `res_idx` out 1 / cnt_bw: `sfp_data_out` holds the final value for pixel `res_idx`.
- `busy`, `done` out 1 / 1: busy in any non-IDLE state; done is a one-cycle pulse.

## Operation
- States: IDLE → W_FILL → W_LOAD → A_FILL → A_EXEC → DRAIN_WAIT → O_READ. After O_READ, the FSM goes to W_FILL with k+1, or to ACC when k = len_kij−1. ACC → DONE → IDLE.
- `len_*` and `w_base` are sampled on the `start` cycle. Later changes have no effect on the run in progress.
- W_FILL: `col` reads at `xmem_addr` = w_base + k·col + i. `l0_wr` is asserted one cycle after each read, because xmem has 1-cycle read latency.
- W_LOAD: `l0_rd` and `load` are asserted together for `col` cycles.
- A_FILL: `len_nij` reads at `xmem_addr` = k·len_nij + n (activation region starts at 0), with `l0_wr` trailing by one cycle. A_FILL ends after the last `l0_wr`.
- A_EXEC: `l0_rd` and `execute` are asserted together for `len_nij` cycles.
- DRAIN_WAIT: all strobes are 0 for `pipe_lat` cycles.
- O_READ: `ofifo_rd` is asserted for `len_nij` cycles. `pmem_wen` trails by one cycle, with `pmem_waddr` = k·len_nij + n.
- ACC: for each o in 0..len_onij−1:
  - A one-cycle `sfp_clr` is issued first.
  - Then, for each k, `pmem_ren` is asserted with `pmem_raddr` = k·len_nij + o, and `acc` is asserted on the following cycle.
  - One cycle after the last `acc`, `res_valid` = 1 with `res_idx` = o.
- Arithmetic:
  - All address products and sums are unsigned and truncated to `cnt_bw`. No overflow detection.
  - Configurations that exceed 2^cnt_bw addresses are illegal.
- `ififo_rd` and `ififo_wr` are always 0 in this revision.

## Timing
- Reset values: `inst` = 0, all enables = 0, all addresses = 0, `res_idx` = 0, `busy` = 0, `done` = 0, state = IDLE.
- Reset is honoured in any state, mid-run included. The FSM returns to IDLE on the next edge with no further strobes.
- All outputs are registered.
- The first `xmem_ren` occurs in the cycle after `start`.
- `start` while busy is ignored.
- Phase boundaries have no idle bubbles other than:
  - the 1-cycle read-latency tail in W_FILL, A_FILL, O_READ and ACC;
  - the `pipe_lat` wait;
  - one `sfp_clr` cycle per output.
- `done` pulses in the cycle after the final `res_valid`. `busy` falls in that same cycle.
- `load` and `execute` are never asserted together. `l0_wr` and `l0_rd` are never asserted together.

## Structure
- A shared package `corelet_pkg` holds:
  - `inst` bit-index constants (LOAD=0 … OFIFO_RD=6, SFP_CLR=32, ACC=33);
  - the state enum.
- One sub-module, `seq_counter`: a loadable up-counter with a terminal-count flag. It is instantiated for the word index, k, and o.

## Test plan
- row=col=8, len_kij=1, len_nij=4, len_onij=4, w_base=100 → exactly 8 `xmem_ren` at addresses 100..107 and 8 `load`+`l0_rd` cycles. Then 4 reads at 0..3, 4 `execute` cycles, 16 idle cycles, 4 `ofifo_rd`, and pmem writes at addresses 0..3.
- len_kij=3, len_nij=4, len_onij=2:
  - weight reads at w_base + 0/8/16 + i;
  - pmem writes at 0..11;
  - ACC reads 0,4,8 then 1,5,9;
  - `res_idx` 0 then 1;
  - one `done` pulse.
- `start` pulsed while busy → trace identical to a single-start run.
- `reset` asserted mid A_EXEC → `inst` = 0 on the next cycle and `busy` = 0. A new `start` produces a clean full trace.
- Every cycle (assertion): mutual exclusion of load/execute and of l0_wr/l0_rd; each `l0_wr` exactly one cycle after a `xmem_ren`.
- len_nij=1, len_kij=1, len_onij=1 minimum → one execute, one pmem write, `sfp_clr`, one `acc`, `res_valid`, then `done`.

Source files
------------

// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet instruction sequencer: inst bit positions,
// counter slot indices and the sequencer state encoding.
package corelet_pkg;
    localparam int INST_W        = 34;
    localparam int INST_LOAD     = 0;
    localparam int INST_EXECUTE  = 1;
    localparam int INST_L0_WR    = 2;
    localparam int INST_L0_RD    = 3;
    localparam int INST_IFIFO_RD = 4;
    localparam int INST_IFIFO_WR = 5;
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_SFP_CLR  = 32;
    localparam int INST_ACC      = 33;

    localparam int CNT_IDX = 0;
    localparam int CNT_K   = 1;
    localparam int CNT_O   = 2;
    localparam int N_CNT   = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_FILL,
        ST_W_LOAD,
        ST_A_FILL,
        ST_A_EXEC,
        ST_DRAIN_WAIT,
        ST_O_READ,
        ST_ACC,
        ST_DONE
    } state_t;
endpackage

// File: rtl/corelet_ctrl_seq_counter.sv
// Loadable up-counter with a terminal-count flag; exposes its next value so the
// owner can compute registered outputs that line up with the new count.
module seq_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         at_term
);
    logic [W-1:0] count_reg;

    always_comb begin
        count_next = count_reg;
        if (load)
            count_next = load_val;
        else if (inc)
            count_next = count_reg + W'(1);
    end

    always_ff @(posedge clk) begin
        if (srst)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

    assign count   = count_reg;
    assign at_term = (count_reg == term_val);
endmodule

// File: rtl/corelet_ctrl.sv
// Sequencer for one convolution layer: weight fill/load, activation fill/execute,
// output drain into pmem per kernel position, then the SFP accumulation pass.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int cnt_bw   = 11,
    parameter int pipe_lat = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        len_kij,
    input  logic [cnt_bw-1:0] len_nij,
    input  logic [cnt_bw-1:0] len_onij,
    input  logic [cnt_bw-1:0] w_base,
    output logic [INST_W-1:0] inst,
    output logic              xmem_ren,
    output logic [cnt_bw-1:0] xmem_addr,
    output logic              pmem_wen,
    output logic [cnt_bw-1:0] pmem_waddr,
    output logic              pmem_ren,
    output logic [cnt_bw-1:0] pmem_raddr,
    output logic              res_valid,
    output logic [cnt_bw-1:0] res_idx,
    output logic              busy,
    output logic              done
);
    localparam int CW = cnt_bw;

    if (row < 1 || col < 1 || pipe_lat < 1) begin : g_param_check
        $error("corelet_ctrl: row, col and pipe_lat must all be at least 1");
    end

    state_t        state_reg, state_next;
    logic [3:0]    kij_reg, kij_next;
    logic [CW-1:0] nij_reg, nij_next, onij_reg, onij_next, wb_reg, wb_next;

    logic          cnt_load    [N_CNT];
    logic          cnt_inc     [N_CNT];
    logic [CW-1:0] cnt_term    [N_CNT];
    logic [CW-1:0] cnt_val     [N_CNT];
    logic [CW-1:0] cnt_nxt     [N_CNT];
    logic          cnt_at_term [N_CNT];

    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
        seq_counter #(.W(CW)) u_cnt (
            .clk       (clk),
            .srst      (reset),
            .load      (cnt_load[gi]),
            .load_val  ('0),
            .inc       (cnt_inc[gi]),
            .term_val  (cnt_term[gi]),
            .count     (cnt_val[gi]),
            .count_next(cnt_nxt[gi]),
            .at_term   (cnt_at_term[gi])
        );
    end

    logic          load_reg, execute_reg, l0_wr_reg, l0_rd_reg, ofifo_rd_reg, sfp_clr_reg, acc_reg;
    logic          load_next, execute_next, l0_rd_next, ofifo_rd_next, sfp_clr_next;
    logic          xmem_ren_reg, xmem_ren_next, pmem_ren_reg, pmem_ren_next;
    logic [CW-1:0] xmem_addr_reg, xmem_addr_next, pmem_raddr_reg, pmem_raddr_next;
    logic          pmem_wen_reg, res_valid_reg, busy_reg, done_reg;
    logic [CW-1:0] pmem_waddr_reg, res_idx_reg;

    // Word-index terminal value: phases with a read-latency tail run one extra step.
    always_comb begin
        cnt_term[CNT_IDX] = '0;
        case (state_reg)
            ST_W_FILL:     cnt_term[CNT_IDX] = CW'(col);
            ST_W_LOAD:     cnt_term[CNT_IDX] = CW'(col - 1);
            ST_A_FILL:     cnt_term[CNT_IDX] = nij_reg;
            ST_A_EXEC:     cnt_term[CNT_IDX] = nij_reg - CW'(1);
            ST_DRAIN_WAIT: cnt_term[CNT_IDX] = CW'(pipe_lat - 1);
            ST_O_READ:     cnt_term[CNT_IDX] = nij_reg;
            ST_ACC:        cnt_term[CNT_IDX] = CW'(kij_reg) + CW'(1);
            default:       cnt_term[CNT_IDX] = '0;
        endcase
        cnt_term[CNT_K] = CW'(kij_reg) - CW'(1);
        cnt_term[CNT_O] = onij_reg - CW'(1);
    end

    always_comb begin
        state_next = state_reg;
        kij_next   = kij_reg;
        nij_next   = nij_reg;
        onij_next  = onij_reg;
        wb_next    = wb_reg;
        for (int i = 0; i < N_CNT; i++) begin
            cnt_load[i] = 1'b0;
            cnt_inc[i]  = 1'b0;
        end
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_W_FILL;
                    kij_next   = len_kij;
                    nij_next   = len_nij;
                    onij_next  = len_onij;
                    wb_next    = w_base;
                    for (int i = 0; i < N_CNT; i++)
                        cnt_load[i] = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: begin
                if (!cnt_at_term[CNT_IDX]) begin
                    cnt_inc[CNT_IDX] = 1'b1;
                end else begin
                    cnt_load[CNT_IDX] = 1'b1;
                    case (state_reg)
                        ST_W_FILL:     state_next = ST_W_LOAD;
                        ST_W_LOAD:     state_next = ST_A_FILL;
                        ST_A_FILL:     state_next = ST_A_EXEC;
                        ST_A_EXEC:     state_next = ST_DRAIN_WAIT;
                        ST_DRAIN_WAIT: state_next = ST_O_READ;
                        ST_O_READ: begin
                            if (cnt_at_term[CNT_K]) begin
                                state_next     = ST_ACC;
                                cnt_load[CNT_O] = 1'b1;
                            end else begin
                                state_next     = ST_W_FILL;
                                cnt_inc[CNT_K] = 1'b1;
                            end
                        end
                        ST_ACC: begin
                            if (cnt_at_term[CNT_O])
                                state_next = ST_DONE;
                            else
                                cnt_inc[CNT_O] = 1'b1;
                        end
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Leading strobes are decoded from the upcoming state/counters so they are
    // registered in step with the state; trailing strobes are delayed copies.
    always_comb begin
        xmem_ren_next   = 1'b0;
        xmem_addr_next  = xmem_addr_reg;
        load_next       = 1'b0;
        execute_next    = 1'b0;
        l0_rd_next      = 1'b0;
        ofifo_rd_next   = 1'b0;
        sfp_clr_next    = 1'b0;
        pmem_ren_next   = 1'b0;
        pmem_raddr_next = pmem_raddr_reg;
        case (state_next)
            ST_W_FILL: begin
                if (cnt_nxt[CNT_IDX] < CW'(col)) begin
                    xmem_ren_next  = 1'b1;
                    xmem_addr_next = wb_next + cnt_nxt[CNT_K] * CW'(col) + cnt_nxt[CNT_IDX];
                end
            end
            ST_W_LOAD: begin
                load_next  = 1'b1;
                l0_rd_next = 1'b1;
            end
            ST_A_FILL: begin
                if (cnt_nxt[CNT_IDX] < nij_next) begin
                    xmem_ren_next  = 1'b1;
                    xmem_addr_next = cnt_nxt[CNT_K] * nij_next + cnt_nxt[CNT_IDX];
                end
            end
            ST_A_EXEC: begin
                execute_next = 1'b1;
                l0_rd_next   = 1'b1;
            end
            ST_O_READ: ofifo_rd_next = (cnt_nxt[CNT_IDX] < nij_next);
            ST_ACC: begin
                if (cnt_nxt[CNT_IDX] == '0) begin
                    sfp_clr_next = 1'b1;
                end else if (cnt_nxt[CNT_IDX] <= CW'(kij_next)) begin
                    pmem_ren_next   = 1'b1;
                    pmem_raddr_next = (cnt_nxt[CNT_IDX] - CW'(1)) * nij_next + cnt_nxt[CNT_O];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            kij_reg        <= '0;
            nij_reg        <= '0;
            onij_reg       <= '0;
            wb_reg         <= '0;
            xmem_ren_reg   <= 1'b0;
            xmem_addr_reg  <= '0;
            load_reg       <= 1'b0;
            execute_reg    <= 1'b0;
            l0_wr_reg      <= 1'b0;
            l0_rd_reg      <= 1'b0;
            ofifo_rd_reg   <= 1'b0;
            sfp_clr_reg    <= 1'b0;
            acc_reg        <= 1'b0;
            pmem_ren_reg   <= 1'b0;
            pmem_raddr_reg <= '0;
            pmem_wen_reg   <= 1'b0;
            pmem_waddr_reg <= '0;
            res_valid_reg  <= 1'b0;
            res_idx_reg    <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            kij_reg        <= kij_next;
            nij_reg        <= nij_next;
            onij_reg       <= onij_next;
            wb_reg         <= wb_next;
            xmem_ren_reg   <= xmem_ren_next;
            xmem_addr_reg  <= xmem_addr_next;
            load_reg       <= load_next;
            execute_reg    <= execute_next;
            l0_rd_reg      <= l0_rd_next;
            ofifo_rd_reg   <= ofifo_rd_next;
            sfp_clr_reg    <= sfp_clr_next;
            pmem_ren_reg   <= pmem_ren_next;
            pmem_raddr_reg <= pmem_raddr_next;
            l0_wr_reg      <= xmem_ren_reg;
            acc_reg        <= pmem_ren_reg;
            pmem_wen_reg   <= ofifo_rd_reg;
            if (ofifo_rd_reg)
                pmem_waddr_reg <= cnt_val[CNT_K] * nij_reg + cnt_val[CNT_IDX];
            // The ACC tail step carries the last acc of this pixel.
            res_valid_reg  <= (state_reg == ST_ACC) && cnt_at_term[CNT_IDX];
            if ((state_reg == ST_ACC) && cnt_at_term[CNT_IDX])
                res_idx_reg <= cnt_val[CNT_O];
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= (state_reg == ST_DONE);
        end
    end

    always_comb begin
        inst                = '0;
        inst[INST_LOAD]     = load_reg;
        inst[INST_EXECUTE]  = execute_reg;
        inst[INST_L0_WR]    = l0_wr_reg;
        inst[INST_L0_RD]    = l0_rd_reg;
        inst[INST_OFIFO_RD] = ofifo_rd_reg;
        inst[INST_SFP_CLR]  = sfp_clr_reg;
        inst[INST_ACC]      = acc_reg;
    end

    assign xmem_ren   = xmem_ren_reg;
    assign xmem_addr  = xmem_addr_reg;
    assign pmem_wen   = pmem_wen_reg;
    assign pmem_waddr = pmem_waddr_reg;
    assign pmem_ren   = pmem_ren_reg;
    assign pmem_raddr = pmem_raddr_reg;
    assign res_valid  = res_valid_reg;
    assign res_idx    = res_idx_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench for corelet_ctrl: a phase-level timing model queues expected
// strobe events per kind; a negedge monitor pops and compares each observed one.
module tb_corelet_ctrl;
    localparam int COL  = 8;
    localparam int PIPE = 16;
    localparam int CW   = 11;
    localparam int MASK = (1 << CW) - 1;
    localparam int NK   = 12;
    localparam int K_XRD = 0, K_L0WR = 1, K_LOAD = 2, K_L0RD = 3, K_EXEC = 4, K_OFIFO = 5;
    localparam int K_PWR = 6, K_PRD = 7, K_CLR = 8, K_ACC = 9, K_RES = 10, K_DONE = 11;
    localparam logic [33:0] USED_BITS = 34'h3_0000_004F;

    typedef struct {
        int cyc;
        int addr;
    } ev_t;

    ev_t exp_q[NK][$];

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    len_kij = '0;
    logic [CW-1:0] len_nij = '0, len_onij = '0, w_base = '0;
    logic [33:0]   inst;
    logic          xmem_ren, pmem_wen, pmem_ren, res_valid, busy, done;
    logic [CW-1:0] xmem_addr, pmem_waddr, pmem_raddr, res_idx;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   busy_lo = 1, busy_hi = 0, exp_done = 0;
    logic prev_xren = 1'b0;
    logic act[NK];
    int   aval[NK];
    ev_t  got;

    corelet_ctrl #(.row(8), .col(COL), .cnt_bw(CW), .pipe_lat(PIPE)) dut (
        .clk(clk), .reset(reset), .start(start), .len_kij(len_kij), .len_nij(len_nij),
        .len_onij(len_onij), .w_base(w_base), .inst(inst), .xmem_ren(xmem_ren),
        .xmem_addr(xmem_addr), .pmem_wen(pmem_wen), .pmem_waddr(pmem_waddr),
        .pmem_ren(pmem_ren), .pmem_raddr(pmem_raddr), .res_valid(res_valid),
        .res_idx(res_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_XRD: return "xmem_read";   K_L0WR: return "l0_wr";     K_LOAD: return "load";
            K_L0RD: return "l0_rd";      K_EXEC: return "execute";   K_OFIFO: return "ofifo_rd";
            K_PWR: return "pmem_write";  K_PRD: return "pmem_read";  K_CLR: return "sfp_clr";
            K_ACC: return "acc";         K_RES: return "res_valid";  default: return "done";
        endcase
    endfunction

    task automatic push(input int k, input int c, input int a);
        ev_t e;
        e.cyc  = c;
        e.addr = a & MASK;
        exp_q[k].push_back(e);
    endtask

    // Reference timing: phases laid end to end, cycle 1 after the start cycle.
    task automatic build_expected(input int s, input int kij, input int nij, input int onij, input int wb);
        int t;
        t = s + 1;
        for (int k = 0; k < kij; k++) begin
            for (int i = 0; i < COL; i++) begin
                push(K_XRD, t + i, wb + k * COL + i);
                push(K_L0WR, t + i + 1, 0);
            end
            t += COL + 1;
            for (int i = 0; i < COL; i++) begin
                push(K_LOAD, t + i, 0);
                push(K_L0RD, t + i, 0);
            end
            t += COL;
            for (int n = 0; n < nij; n++) begin
                push(K_XRD, t + n, k * nij + n);
                push(K_L0WR, t + n + 1, 0);
            end
            t += nij + 1;
            for (int n = 0; n < nij; n++) begin
                push(K_EXEC, t + n, 0);
                push(K_L0RD, t + n, 0);
            end
            t += nij + PIPE;
            for (int n = 0; n < nij; n++) begin
                push(K_OFIFO, t + n, 0);
                push(K_PWR, t + n + 1, k * nij + n);
            end
            t += nij + 1;
        end
        for (int o = 0; o < onij; o++) begin
            push(K_CLR, t, 0);
            for (int k = 0; k < kij; k++) begin
                push(K_PRD, t + 1 + k, k * nij + o);
                push(K_ACC, t + 2 + k, 0);
            end
            push(K_RES, t + kij + 2, o);
            t += kij + 2;
        end
        push(K_DONE, t + 1, 0);
        exp_done = t + 1;
        busy_lo  = s + 1;
        busy_hi  = t;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NK; k++) aval[k] = 0;
            act[K_XRD] = xmem_ren;   aval[K_XRD] = int'(xmem_addr);
            act[K_L0WR] = inst[2];   act[K_LOAD] = inst[0];   act[K_L0RD] = inst[3];
            act[K_EXEC] = inst[1];   act[K_OFIFO] = inst[6];
            act[K_PWR] = pmem_wen;   aval[K_PWR] = int'(pmem_waddr);
            act[K_PRD] = pmem_ren;   aval[K_PRD] = int'(pmem_raddr);
            act[K_CLR] = inst[32];   act[K_ACC] = inst[33];
            act[K_RES] = res_valid;  aval[K_RES] = int'(res_idx);
            act[K_DONE] = done;
            for (int k = 0; k < NK; k++) begin
                if (act[k]) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL %s: got event addr=%0d at cycle %0d, required no event", kname(k), aval[k], cyc);
                    end else begin
                        got = exp_q[k].pop_front();
                        if (got.cyc != cyc || got.addr != aval[k]) begin
                            errors++;
                            $display("FAIL %s: got addr=%0d at cycle %0d, required addr=%0d at cycle %0d",
                                     kname(k), aval[k], cyc, got.addr, got.cyc);
                        end
                    end
                end
            end
            checks++;
            if ((inst[0] && inst[1]) || (inst[2] && inst[3])) begin
                errors++;
                $display("FAIL exclusion at cycle %0d: got inst=%h, required load/execute and l0_wr/l0_rd disjoint", cyc, inst);
            end
            checks++;
            if (inst[2] !== prev_xren) begin
                errors++;
                $display("FAIL l0_wr_lag at cycle %0d: got l0_wr=%b, required %b", cyc, inst[2], prev_xren);
            end
            checks++;
            if ((inst & ~USED_BITS) != '0) begin
                errors++;
                $display("FAIL inst_unused at cycle %0d: got inst=%h, required unused bits 0", cyc, inst);
            end
            checks++;
            if (busy !== ((cyc >= busy_lo) && (cyc <= busy_hi))) begin
                errors++;
                $display("FAIL busy at cycle %0d: got %b, required %b", cyc, busy, (cyc >= busy_lo) && (cyc <= busy_hi));
            end
        end
        prev_xren = reset ? 1'b0 : xmem_ren;
    end

    task automatic check_val(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // reset_off > 0: assert reset that many cycles after the start cycle and abandon the run.
    task automatic run_cfg(input int kij, input int nij, input int onij, input int wb,
                           input bit extra_start, input int reset_off);
        int s;
        @(posedge clk); #1;
        len_kij  = 4'(kij);
        len_nij  = CW'(nij);
        len_onij = CW'(onij);
        w_base   = CW'(wb);
        start    = 1'b1;
        s = cyc;
        build_expected(s, kij, nij, onij, wb);
        $display("run kij=%0d nij=%0d onij=%0d w_base=%0d extra_start=%0d reset_off=%0d",
                 kij, nij, onij, wb, extra_start, reset_off);
        @(posedge clk); #1;
        start    = 1'b0;
        len_kij  = 4'($urandom_range(1, 15));
        len_nij  = CW'($urandom_range(1, 50));
        len_onij = CW'($urandom_range(1, 50));
        w_base   = CW'($urandom_range(0, MASK));
        if (extra_start) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (reset_off > 0) begin
            while (cyc < s + reset_off) begin
                @(posedge clk); #1;
            end
            reset = 1'b1;
            @(posedge clk); #1;
            reset   = 1'b0;
            busy_hi = cyc - 1;
            for (int k = 0; k < NK; k++) exp_q[k].delete();
            check_val("inst_after_reset", (inst == '0) ? 0 : 1, 0);
            check_val("busy_after_reset", int'(busy), 0);
        end else begin
            while (cyc < exp_done + 2) begin
                @(posedge clk); #1;
            end
            for (int k = 0; k < NK; k++)
                check_val({kname(k), "_missing"}, exp_q[k].size(), 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_inst", (inst == '0) ? 0 : 1, 0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_done", int'(done), 0);
        check_val("reset_xmem", int'(xmem_ren) + int'(xmem_addr), 0);
        check_val("reset_pmem", int'(pmem_wen) + int'(pmem_ren) + int'(pmem_waddr) + int'(pmem_raddr), 0);
        check_val("reset_res", int'(res_valid) + int'(res_idx), 0);
        reset = 1'b0;
        run_cfg(1, 4, 4, 100, 1'b0, 0);
        run_cfg(3, 4, 2, 100, 1'b0, 0);
        run_cfg(2, 3, 2, 37, 1'b1, 0);
        run_cfg(2, 4, 2, 55, 1'b0, 2 * COL + 4 + 4);
        run_cfg(2, 4, 2, 55, 1'b0, 0);
        run_cfg(1, 1, 1, 0, 1'b0, 0);
        for (int r = 0; r < 4; r++) begin
            int nij;
            nij = $urandom_range(1, 10);
            run_cfg($urandom_range(1, 4), nij, $urandom_range(1, nij), $urandom_range(0, MASK), 1'b0, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
